// File: rtl/rpi_gpio_capture.sv
// ---------------------------------------------------------------------------
// rpi_gpio_capture : RPi parallel GPIO oversampling capture into FWFT FIFO
// Optional: define RPI_CAP_DROPCNT_EN for the saturating drop_count output.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module rpi_gpio_capture #(
  parameter int DATA_W          = 16,
  parameter int DEPTH_LOG2      = 10,
  parameter int READY_THRESHOLD = 768,
  parameter int EDGE_MODE       = 0,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  gpio_strobe,
  input  logic [DATA_W-1:0]     gpio_data,
  output logic                  rpi_ready,
  output logic [DATA_W-1:0]     m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DEPTH_LOG2:0]   fill,
  output logic                  overflow,
  input  logic                  clr_overflow
`ifdef RPI_CAP_DROPCNT_EN
  ,
  output logic [15:0]           drop_count
`endif
);

  localparam logic [DEPTH_LOG2:0] c_depth  = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0] c_thresh = (DEPTH_LOG2+1)'(READY_THRESHOLD);

  logic [SYNC_STAGES-1:0] r_strb_sync;
  logic [DATA_W-1:0]      r_data_sync [SYNC_STAGES];
  logic                   r_strb_prev;
  // r_live[i] marks that stage i holds a post-reset sample; the top bit covers r_strb_prev
  logic [SYNC_STAGES:0]   r_live;

  logic                   w_rise, w_fall, w_edge;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_strb_sync <= '0;
      r_strb_prev <= 1'b0;
      r_live      <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) r_data_sync[i] <= '0;
    end else begin
      r_strb_sync    <= {r_strb_sync[SYNC_STAGES-2:0], gpio_strobe};
      r_data_sync[0] <= gpio_data;
      for (int i = 1; i < SYNC_STAGES; i++) r_data_sync[i] <= r_data_sync[i-1];
      r_strb_prev    <= r_strb_sync[SYNC_STAGES-1];
      r_live         <= {r_live[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign w_rise = r_live[SYNC_STAGES] &  r_strb_sync[SYNC_STAGES-1] & ~r_strb_prev;
  assign w_fall = r_live[SYNC_STAGES] & ~r_strb_sync[SYNC_STAGES-1] &  r_strb_prev;
  assign w_edge = (EDGE_MODE == 0) ? w_fall :
                  (EDGE_MODE == 1) ? w_rise : (w_rise | w_fall);

  logic [DATA_W-1:0]     r_mem [1 << DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
  logic [DATA_W-1:0]     r_rd_data, r_out_data;
  logic                  r_rd_valid, r_out_valid;
  logic [DEPTH_LOG2:0]   r_fill;
  logic                  r_rpi_ready, r_overflow;

  logic                  w_full, w_push, w_drop, w_pop, w_out_load, w_rd_issue;
  logic [DEPTH_LOG2:0]   w_ram_cnt, w_fill_next;

  // fill covers array words, the registered-read stage and the output register
  assign w_full      = (r_fill == c_depth);
  assign w_push      = w_edge & ~w_full;
  assign w_drop      = w_edge &  w_full;
  assign w_pop       = r_out_valid & m_ready;
  assign w_ram_cnt   = r_fill - (DEPTH_LOG2+1)'(r_rd_valid) - (DEPTH_LOG2+1)'(r_out_valid);
  assign w_out_load  = r_rd_valid & (~r_out_valid | w_pop);
  assign w_rd_issue  = (w_ram_cnt != '0) & (~r_rd_valid | w_out_load);
  assign w_fill_next = r_fill + (DEPTH_LOG2+1)'(w_push) - (DEPTH_LOG2+1)'(w_pop);

  always_ff @(posedge clk) begin
    if (w_push)     r_mem[r_wr_ptr] <= r_data_sync[SYNC_STAGES-1];
    if (w_rd_issue) r_rd_data       <= r_mem[r_rd_ptr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_rd_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_fill      <= '0;
      r_rpi_ready <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_push)     r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_rd_valid  <= w_rd_issue | (r_rd_valid & ~w_out_load);
      r_out_valid <= w_out_load | (r_out_valid & ~w_pop);
      if (w_out_load) r_out_data <= r_rd_data;
      r_fill      <= w_fill_next;
      // Flow control trails the visible fill count by one cycle
      r_rpi_ready <= (r_fill < c_thresh);
      if (clr_overflow) r_overflow <= 1'b0;
      else if (w_drop)  r_overflow <= 1'b1;
    end
  end

`ifdef RPI_CAP_DROPCNT_EN
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               r_drop_cnt <= '0;
    else if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
  end

  assign drop_count = r_drop_cnt;
`endif

  assign rpi_ready = r_rpi_ready;
  assign m_data    = r_out_data;
  assign m_valid   = r_out_valid;
  assign fill      = r_fill;
  assign overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_rpi_gpio_capture.sv
// ---------------------------------------------------------------------------
// tb_rpi_gpio_capture : randomized self-checking bench with queue scoreboard
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rpi_gpio_capture;

  localparam int A_DEPTH = 16;
  localparam int A_THR   = 12;
  localparam int SYNC    = 2;

  logic        clk;
  logic        rst;
  logic        a_strobe, a_valid, a_ready, a_rdy, a_ovf, a_clr;
  logic [15:0] a_data, a_mdata;
  logic [4:0]  a_fill;
  logic        b_strobe, b_valid, b_ready, b_rdy, b_ovf, b_clr;
  logic [15:0] b_data, b_mdata;
  logic [10:0] b_fill;
`ifdef RPI_CAP_DROPCNT_EN
  logic [15:0] a_dcnt, b_dcnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] a_q[$];
  logic [15:0] b_q[$];
  int a_drops = 0;
  int a_pops  = 0;
  int b_pops  = 0;

  rpi_gpio_capture #(.DATA_W(16), .DEPTH_LOG2(4), .READY_THRESHOLD(A_THR),
                     .EDGE_MODE(0), .SYNC_STAGES(SYNC)) u_dut_a (
    .clk(clk), .reset(rst), .gpio_strobe(a_strobe), .gpio_data(a_data),
    .rpi_ready(a_rdy), .m_data(a_mdata), .m_valid(a_valid), .m_ready(a_ready),
    .fill(a_fill), .overflow(a_ovf), .clr_overflow(a_clr)
`ifdef RPI_CAP_DROPCNT_EN
    , .drop_count(a_dcnt)
`endif
  );

  rpi_gpio_capture #(.EDGE_MODE(2)) u_dut_b (
    .clk(clk), .reset(rst), .gpio_strobe(b_strobe), .gpio_data(b_data),
    .rpi_ready(b_rdy), .m_data(b_mdata), .m_valid(b_valid), .m_ready(b_ready),
    .fill(b_fill), .overflow(b_ovf), .clr_overflow(b_clr)
`ifdef RPI_CAP_DROPCNT_EN
    , .drop_count(b_dcnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboards: a transfer happens at the posedge following a negedge seeing valid & ready
  int          a_prev_fill = 0;
  bit          a_prev_rst  = 1'b1;
  logic        a_exp_rdy;
  logic [15:0] a_exp, b_exp;

  always @(negedge clk) begin
    if (a_valid === 1'b1 && a_ready === 1'b1) begin
      n_vec++;
      a_pops++;
      if (a_q.size() == 0) begin
        n_err++;
        $display("FAIL a_pop_unexpected got=%h expected=<none>", a_mdata);
      end else begin
        a_exp = a_q.pop_front();
        if (a_mdata !== a_exp) begin
          n_err++;
          $display("FAIL a_stream got=%h expected=%h", a_mdata, a_exp);
        end
      end
    end
    n_vec++;
    if (!(int'(a_fill) <= A_DEPTH)) begin
      n_err++;
      $display("FAIL a_fill_bound got=%0d expected<=%0d", a_fill, A_DEPTH);
    end
    a_exp_rdy = (rst || a_prev_rst) ? 1'b0 : (a_prev_fill < A_THR);
    n_vec++;
    if (a_rdy !== a_exp_rdy) begin
      n_err++;
      $display("FAIL a_rpi_ready got=%b expected=%b (prev fill %0d)", a_rdy, a_exp_rdy, a_prev_fill);
    end
    a_prev_fill = int'(a_fill);
    a_prev_rst  = rst;
  end

  always @(negedge clk) begin
    if (b_valid === 1'b1 && b_ready === 1'b1) begin
      n_vec++;
      b_pops++;
      if (b_q.size() == 0) begin
        n_err++;
        $display("FAIL b_pop_unexpected got=%h expected=<none>", b_mdata);
      end else begin
        b_exp = b_q.pop_front();
        if (b_mdata !== b_exp) begin
          n_err++;
          $display("FAIL b_stream got=%h expected=%h", b_mdata, b_exp);
        end
      end
    end
  end

  // One falling-edge word on DUT A; the model decides push/drop from its own occupancy
  task automatic send_a(input logic [15:0] d, input bit pop_at_push);
    @(negedge clk);
    a_data = d;
    repeat (2) @(negedge clk);
    a_strobe = 1'b0;
    if (a_q.size() < A_DEPTH) a_q.push_back(d);
    else                      a_drops++;
    if (pop_at_push) begin
      @(posedge clk);
      @(posedge clk); #1 a_ready = 1'b1;
      @(posedge clk); #1 a_ready = 1'b0;
    end else begin
      repeat (3) @(negedge clk);
    end
    @(negedge clk);
    a_strobe = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL rst_a_valid got=%b expected=0", a_valid); end
    n_vec++; if (a_mdata !== 16'h0) begin n_err++; $display("FAIL rst_a_data got=%h expected=0000", a_mdata); end
    n_vec++; if (a_fill !== 5'd0) begin n_err++; $display("FAIL rst_a_fill got=%0d expected=0", a_fill); end
    n_vec++; if (a_ovf !== 1'b0) begin n_err++; $display("FAIL rst_a_ovf got=%b expected=0", a_ovf); end
    n_vec++; if (b_valid !== 1'b0 || b_fill !== 11'd0 || b_rdy !== 1'b0) begin
      n_err++; $display("FAIL rst_b got=v%b f%0d r%b expected=v0 f0 r0", b_valid, b_fill, b_rdy);
    end
`ifdef RPI_CAP_DROPCNT_EN
    n_vec++; if (a_dcnt !== 16'd0) begin n_err++; $display("FAIL rst_a_dcnt got=%0d expected=0", a_dcnt); end
`endif
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (b_rdy !== 1'b1) begin n_err++; $display("FAIL rst_first_ready got=%b expected=1", b_rdy); end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic();
    int k;
    logic [15:0] words [4];
    words[0] = 16'h1234; words[1] = 16'h5678; words[2] = 16'h9ABC; words[3] = 16'hDEF0;
    @(posedge clk); #1 a_ready = 1'b1;
    @(negedge clk);
    a_data = words[0];
    repeat (2) @(negedge clk);
    a_strobe = 1'b0;
    a_q.push_back(words[0]);
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (a_valid !== 1'b1 && k < 20);
    n_vec++;
    if (k != SYNC + 3) begin
      n_err++; $display("FAIL first_valid_latency got=%0d edges expected=%0d", k, SYNC + 3);
    end
    @(negedge clk); a_strobe = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 1; i < 4; i++) send_a(words[i], 1'b0);
    repeat (10) @(negedge clk);
    n_vec++; if (a_q.size() != 0) begin n_err++; $display("FAIL basic_drain got=%0d left expected=0", a_q.size()); end
    n_vec++; if (a_fill !== 5'd0) begin n_err++; $display("FAIL basic_fill got=%0d expected=0", a_fill); end
    n_vec++; if (a_ovf !== 1'b0) begin n_err++; $display("FAIL basic_ovf got=%b expected=0", a_ovf); end
  endtask

  task automatic test_ddr();
    int pops0;
    @(posedge clk); #1 rst = 1'b1;
    b_strobe = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    n_vec++; if (b_valid !== 1'b0 || b_fill !== 11'd0) begin
      n_err++; $display("FAIL ddr_no_spurious got=v%b f%0d expected=v0 f0", b_valid, b_fill);
    end
    @(posedge clk); #1 b_ready = 1'b1;
    pops0 = b_pops;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      b_data = 16'(i);
      repeat (2) @(negedge clk);
      b_strobe = ~b_strobe;
      b_q.push_back(16'(i));
      repeat (3) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    n_vec++; if (b_pops - pops0 != 6) begin n_err++; $display("FAIL ddr_count got=%0d expected=6", b_pops - pops0); end
    n_vec++; if (b_fill !== 11'd0) begin n_err++; $display("FAIL ddr_fill got=%0d expected=0", b_fill); end
  endtask

  task automatic test_fill_threshold();
    @(posedge clk); #1 a_ready = 1'b0;
    for (int i = 0; i < A_DEPTH; i++) send_a(16'h0100 + 16'(i), 1'b0);
    repeat (5) @(negedge clk);
    n_vec++; if (a_fill !== 5'd16) begin n_err++; $display("FAIL full_fill got=%0d expected=16", a_fill); end
    n_vec++; if (a_rdy !== 1'b0) begin n_err++; $display("FAIL full_ready got=%b expected=0", a_rdy); end
    n_vec++; if (a_ovf !== 1'b0) begin n_err++; $display("FAIL full_ovf got=%b expected=0", a_ovf); end
  endtask

  task automatic test_overflow();
    send_a(16'hDEAD, 1'b0);
    send_a(16'hBEEF, 1'b0);
    send_a(16'hCAFE, 1'b1);
    repeat (5) @(negedge clk);
    n_vec++; if (a_ovf !== (a_drops > 0)) begin n_err++; $display("FAIL ovf_set got=%b expected=%b", a_ovf, a_drops > 0); end
    n_vec++; if (int'(a_fill) != a_q.size()) begin n_err++; $display("FAIL ovf_fill got=%0d expected=%0d", a_fill, a_q.size()); end
`ifdef RPI_CAP_DROPCNT_EN
    n_vec++; if (int'(a_dcnt) != a_drops) begin n_err++; $display("FAIL ovf_dcnt got=%0d expected=%0d", a_dcnt, a_drops); end
`endif
    @(posedge clk); #1 a_clr = 1'b1;
    @(posedge clk); #1 a_clr = 1'b0;
    n_vec++; if (a_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clear got=%b expected=0", a_ovf); end
`ifdef RPI_CAP_DROPCNT_EN
    n_vec++; if (int'(a_dcnt) != a_drops) begin n_err++; $display("FAIL dcnt_keep got=%0d expected=%0d", a_dcnt, a_drops); end
`endif
    @(posedge clk); #1 a_ready = 1'b1;
    repeat (30) @(negedge clk);
    n_vec++; if (a_q.size() != 0 || a_fill !== 5'd0) begin
      n_err++; $display("FAIL ovf_drain got=%0d left fill %0d expected=0", a_q.size(), a_fill);
    end
  endtask

  task automatic test_reset_midburst();
    int pops0;
    @(posedge clk); #1 a_ready = 1'b0;
    for (int i = 0; i < 9; i++) send_a(16'h0900 + 16'(i), 1'b0);
    repeat (3) @(negedge clk);
    n_vec++; if (a_fill !== 5'd9) begin n_err++; $display("FAIL mid_fill got=%0d expected=9", a_fill); end
    @(negedge clk); a_data = 16'h7777;
    repeat (2) @(negedge clk);
    a_strobe = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    a_q.delete();
    @(negedge clk);
    n_vec++; if (a_valid !== 1'b0 || a_mdata !== 16'h0 || a_fill !== 5'd0 || a_ovf !== 1'b0 || a_rdy !== 1'b0) begin
      n_err++; $display("FAIL mid_reset got=v%b d%h f%0d o%b r%b expected=all zero", a_valid, a_mdata, a_fill, a_ovf, a_rdy);
    end
    a_strobe = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    @(posedge clk); #1 a_ready = 1'b1;
    pops0 = a_pops;
    for (int i = 0; i < 3; i++) send_a(16'hA001 + 16'(i), 1'b0);
    repeat (20) @(negedge clk);
    n_vec++; if (a_pops - pops0 != 3 || a_q.size() != 0) begin
      n_err++; $display("FAIL mid_restart got=%0d words expected=3", a_pops - pops0);
    end
  endtask

  task automatic test_random();
    bit done;
    int w;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          w = 0;
          @(negedge clk);
          while (a_rdy !== 1'b1 && w < 500) begin @(negedge clk); w++; end
          if (w >= 500) begin
            n_vec++; n_err++;
            $display("FAIL rand_ready_timeout got=0 expected=1 at word %0d", i);
            break;
          end
          send_a(16'($urandom), 1'b0);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1 a_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    @(posedge clk); #1 a_ready = 1'b1;
    w = 0;
    while (a_q.size() != 0 && w < 500) begin @(negedge clk); w++; end
    repeat (3) @(negedge clk);
    n_vec++; if (a_q.size() != 0) begin n_err++; $display("FAIL rand_drain got=%0d left expected=0", a_q.size()); end
    n_vec++; if (a_fill !== 5'd0) begin n_err++; $display("FAIL rand_fill got=%0d expected=0", a_fill); end
    n_vec++; if (a_ovf !== 1'b0 || a_drops != 3) begin
      n_err++; $display("FAIL rand_ovf got=%b drops %0d expected=0 drops 3", a_ovf, a_drops);
    end
  endtask

  initial begin
    rst      = 1'b1;
    a_strobe = 1'b1; a_data = '0; a_ready = 1'b0; a_clr = 1'b0;
    b_strobe = 1'b1; b_data = '0; b_ready = 1'b0; b_clr = 1'b0;
    test_reset();
    test_basic();
    test_ddr();
    test_fill_threshold();
    test_overflow();
    test_reset_midburst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
